// File: rtl/shift_register_univ.sv
// Universal shift register: parallel load and clear, plus logical, arithmetic and rotate
// shifts that run a commanded number of steps. Commands arrive over a valid/ready handshake.
module shift_register_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ser_i,
  input  logic             stall_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             ser_reg, ser_next;
  logic             done_reg, done_next;
  logic [2:0]       op_reg, op_next;
  logic [CNT_W-1:0] rem_reg, rem_next;

  // One shift step; the result is {bit shifted out, new contents}.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] op,
                                             input logic [WIDTH-1:0] d,
                                             input logic fill,
                                             input logic ser_cur);
    logic [WIDTH:0] r;
    r = {ser_cur, d};
    unique case (op)
      OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], fill};
      OP_SHR:  r = {d[0], fill, d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      OP_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {ser_cur, d};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      ser_reg   <= 1'b0;
      done_reg  <= 1'b0;
      op_reg    <= OP_NOP;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      ser_reg   <= ser_next;
      done_reg  <= done_next;
      op_reg    <= op_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    ser_next   = ser_reg;
    done_next  = 1'b0;
    op_next    = op_reg;
    rem_next   = rem_reg;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          unique case (cmd_op_i)
            OP_NOP: done_next = 1'b1;
            OP_LOAD: begin
              data_next = load_data_i;
              done_next = 1'b1;
            end
            OP_CLR: begin
              data_next = '0;
              ser_next  = 1'b0;
              done_next = 1'b1;
            end
            default: begin
              // First step executes at the accept edge regardless of stall_i.
              if (cmd_cnt_i == '0) begin
                done_next = 1'b1;
              end else begin
                {ser_next, data_next} = step_fn(cmd_op_i, data_reg, ser_i, ser_reg);
                op_next  = cmd_op_i;
                rem_next = cmd_cnt_i - 1'b1;
                if (cmd_cnt_i == CNT_W'(1)) begin
                  done_next = 1'b1;
                end else begin
                  state_next = SHIFT;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        if (!stall_i) begin
          {ser_next, data_next} = step_fn(op_reg, data_reg, ser_i, ser_reg);
          rem_next = rem_reg - 1'b1;
          if (rem_reg == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = (state_reg == SHIFT);
  assign cmd_ready_o = !busy_o;
  assign data_o      = data_reg;
  assign ser_o       = ser_reg;
  assign done_o      = done_reg;

endmodule
